// File: rtl/stream_switch_scheduler.sv
// Three-source serializer: fixed-source or timed round-robin.
// Define PARITY_EN to append an even-parity bit to every word.
module stream_switch_scheduler #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [2:0]        mode,
    input  logic [CNT_W-1:0]  symbol_clk_cycles,
    input  logic [CNT_W-1:0]  switch_clk_cycles,
    input  logic [DATA_W-1:0] data_0,
    input  logic [DATA_W-1:0] data_1,
    input  logic [DATA_W-1:0] data_2,
    input  logic              valid_0,
    input  logic              valid_1,
    input  logic              valid_2,
    output logic              ready_0,
    output logic              ready_1,
    output logic              ready_2,
    output logic [1:0]        sel,
    output logic              d_out,
    output logic              d_valid,
    output logic              symbol_strobe
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT
    } state_t;

`ifdef PARITY_EN
    localparam int NBITS = DATA_W + 1;
`else
    localparam int NBITS = DATA_W;
`endif
    localparam int BC_W = $clog2(NBITS + 1);

    state_t            state_q;
    state_t            state_d;
    logic [1:0]        sel_q;
    logic [DATA_W-1:0] shift_q;
    logic [CNT_W-1:0]  sym_cnt;
    logic [BC_W-1:0]   bit_cnt;
    logic [CNT_W-1:0]  sw_cnt;
    logic              pending;
    logic              fill;
`ifdef PARITY_EN
    logic              par_q;
`endif

    logic [CNT_W-1:0]  sym_per;
    logic [CNT_W-1:0]  sw_per;
    logic              sym_last;
    logic              word_last;
    logic              go;
    logic              rr;
    logic [3:0]        valid_v;
    logic [1:0]        cand1;
    logic [1:0]        cand2;
    logic [1:0]        pick_sel;
    logic              pick_hit;
    logic              take;
    logic              sw_take;
    logic [DATA_W-1:0] data_mux;

    function automatic logic [1:0] nxt3(input logic [1:0] s);
        return (s == 2'd2) ? 2'd0 : s + 2'd1;
    endfunction

    assign sym_per = (symbol_clk_cycles == '0) ?
                     CNT_W'(1) : symbol_clk_cycles;
    assign sw_per  = (switch_clk_cycles == '0) ?
                     CNT_W'(1) : switch_clk_cycles;
    assign sym_last  = (sym_cnt == sym_per - CNT_W'(1));
    assign word_last = sym_last &&
                       (bit_cnt == BC_W'(NBITS - 1));
    assign go      = enable & ~mode[2];
    assign rr      = (mode == 3'b011);
    assign valid_v = {1'b0, valid_2, valid_1, valid_0};
    assign cand1   = nxt3(sel_q);
    assign cand2   = nxt3(cand1);

    // A pending switch looks past the current source first.
    always_comb begin
        pick_sel = sel_q;
        pick_hit = 1'b0;
        if (rr) begin
            if (!pending && valid_v[sel_q]) begin
                pick_hit = 1'b1;
            end else if (valid_v[cand1]) begin
                pick_sel = cand1;
                pick_hit = 1'b1;
            end else if (valid_v[cand2]) begin
                pick_sel = cand2;
                pick_hit = 1'b1;
            end else if (valid_v[sel_q]) begin
                pick_hit = 1'b1;
            end
        end else begin
            pick_sel = mode[1:0];
            pick_hit = valid_v[mode[1:0]];
        end
    end

    assign take    = (state_q == LOAD) & go & pick_hit;
    assign sw_take = take & pending & rr;

    always_comb begin
        case (pick_sel)
            2'd0:    data_mux = data_0;
            2'd1:    data_mux = data_1;
            default: data_mux = data_2;
        endcase
    end

`ifdef PARITY_EN
    assign fill = par_q;
`else
    assign fill = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (go) state_d = LOAD;
            end
            LOAD: begin
                if (!go)       state_d = IDLE;
                else if (take) state_d = SHIFT;
            end
            SHIFT: begin
                if (word_last) state_d = LOAD;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        d_valid       = (state_q == SHIFT);
        d_out         = d_valid & shift_q[DATA_W-1];
        symbol_strobe = d_valid & sym_last;
        ready_0       = take & (pick_sel == 2'd0);
        ready_1       = take & (pick_sel == 2'd1);
        ready_2       = take & (pick_sel == 2'd2);
        sel           = sel_q;
        if (state_q == LOAD && go) sel = pick_sel;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sel_q   <= 2'd0;
            shift_q <= '0;
            sym_cnt <= '0;
            bit_cnt <= '0;
        end else if (state_q == LOAD && go) begin
            sel_q <= pick_sel;
            if (take) begin
                shift_q <= data_mux;
                sym_cnt <= '0;
                bit_cnt <= '0;
            end
        end else if (state_q == SHIFT) begin
            if (sym_last) begin
                sym_cnt <= '0;
                bit_cnt <= bit_cnt + BC_W'(1);
                shift_q <= {shift_q[DATA_W-2:0], fill};
            end else begin
                sym_cnt <= sym_cnt + CNT_W'(1);
            end
        end
    end

`ifdef PARITY_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            par_q <= 1'b0;
        end else if (take) begin
            par_q <= ^data_mux;
        end
    end
`endif

    // Dwell timer freezes once the switch request is latched.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sw_cnt  <= '0;
            pending <= 1'b0;
        end else if (!rr || sw_take) begin
            sw_cnt  <= '0;
            pending <= 1'b0;
        end else if (state_q != IDLE && !pending) begin
            if (sw_cnt == sw_per - CNT_W'(1)) begin
                pending <= 1'b1;
            end else begin
                sw_cnt <= sw_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_stream_switch_scheduler.sv
// Scoreboard bench for stream_switch_scheduler.
// Honours PARITY_EN to expect the extra parity bit.
module tb_stream_switch_scheduler;

`ifdef PARITY_EN
    localparam int NB = 9;
`else
    localparam int NB = 8;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic [2:0]  mode = 3'd0;
    logic [31:0] sym = 32'd2;
    logic [31:0] swc = 32'd20;
    logic [7:0]  d0 = 8'hCC;
    logic [7:0]  d1 = 8'h5A;
    logic [7:0]  d2 = 8'h33;
    logic        v0 = 1'b0;
    logic        v1 = 1'b0;
    logic        v2 = 1'b0;
    logic        ready_0, ready_1, ready_2;
    logic [1:0]  sel;
    logic        d_out, d_valid, symbol_strobe;

    always #5 clk = ~clk;

    stream_switch_scheduler #(.DATA_W(8), .CNT_W(32)) dut (
        .clk(clk),
        .rst(rst),
        .enable(enable),
        .mode(mode),
        .symbol_clk_cycles(sym),
        .switch_clk_cycles(swc),
        .data_0(d0),
        .data_1(d1),
        .data_2(d2),
        .valid_0(v0),
        .valid_1(v1),
        .valid_2(v2),
        .ready_0(ready_0),
        .ready_1(ready_1),
        .ready_2(ready_2),
        .sel(sel),
        .d_out(d_out),
        .d_valid(d_valid),
        .symbol_strobe(symbol_strobe)
    );

    typedef struct {
        logic [1:0] sel;
        logic [8:0] bits;
        int         s;
    } exp_t;

    exp_t       sb[$];
    exp_t       e;
    int         total = 0;
    int         bad = 0;
    int         nbit = 0;
    int         dv_cnt = 0;
    int         rdy_cnt = 0;
    int         cyc = 0;
    int         last_rdy = 0;
    int         gap = 0;
    logic [8:0] bits = '0;
    logic [1:0] cap_sel = '0;
    bit         r1_seen = 1'b0;

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [8:0] ebits(input logic [7:0] d);
`ifdef PARITY_EN
        return {d, ^d};
`else
        return {1'b0, d};
`endif
    endfunction

    task automatic push(input logic [1:0] s,
                        input logic [7:0] d,
                        input int sp);
        exp_t x;
        x.sel  = s;
        x.bits = ebits(d);
        x.s    = sp;
        sb.push_back(x);
    endtask

    always @(posedge clk) begin
        #1;
        cyc++;
        if (!rst) begin
            nbit    = 0;
            dv_cnt  = 0;
            rdy_cnt = 0;
            bits    = '0;
        end else begin
            chk("ready_onehot",
                32'($countones({ready_2, ready_1, ready_0}) <= 1),
                32'd1);
            if (ready_1) r1_seen = 1'b1;
            if (ready_0 | ready_1 | ready_2) begin
                rdy_cnt++;
                cap_sel  = sel;
                gap      = cyc - last_rdy;
                last_rdy = cyc;
            end
            if (d_valid) begin
                dv_cnt++;
                if (symbol_strobe) begin
                    bits = {bits[7:0], d_out};
                    nbit++;
                end
            end
            if (nbit == NB) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $error("FAIL unexpected_word obs=%0h exp=none",
                           bits);
                end else begin
                    e = sb.pop_front();
                    chk("word_sel", 32'(cap_sel), 32'(e.sel));
                    chk("word_bits", 32'(bits), 32'(e.bits));
                    chk("word_dvalid", dv_cnt, NB * e.s);
                    chk("word_ready", rdy_cnt, 1);
                end
                nbit    = 0;
                dv_cnt  = 0;
                rdy_cnt = 0;
                bits    = '0;
            end
        end
    end

    task automatic wait_empty(input string tag);
        int n = 0;
        while (sb.size() != 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        enable = 1'b0;
        chk(tag, sb.size(), 0);
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_bits(input string tag, input int k);
        int n = 0;
        while (nbit < k && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(nbit >= k), 32'd1);
    endtask

    task automatic do_reset();
        enable = 1'b0;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #1 rst = 1'b0;
        #1;
        chk("rst_sel", 32'(sel), 32'd0);
        chk("rst_dout", 32'(d_out), 32'd0);
        chk("rst_dvalid", 32'(d_valid), 32'd0);
        chk("rst_ready", 32'({ready_2, ready_1, ready_0}), 32'd0);
        chk("rst_strobe", 32'(symbol_strobe), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        mode = 3'b000; sym = 32'd2; v0 = 1'b1;
        push(2'd0, 8'hCC, 2);
        push(2'd0, 8'hCC, 2);
        enable = 1'b1;
        wait_empty("fixed_done");
        chk("fixed_period", gap, NB * 2 + 1);

        do_reset();
        mode = 3'b011; sym = 32'd2; swc = 32'd20;
        v0 = 1'b1; v1 = 1'b1; v2 = 1'b1;
        push(2'd0, d0, 2);
        push(2'd0, d0, 2);
        push(2'd1, d1, 2);
        enable = 1'b1;
        wait_empty("rr_done");
        chk("rr_period", gap, NB * 2 + 1);

        do_reset();
        mode = 3'b011; swc = 32'd1; v1 = 1'b0;
        push(2'd0, d0, 2);
        push(2'd2, d2, 2);
        push(2'd0, d0, 2);
        push(2'd2, d2, 2);
        r1_seen = 1'b0;
        enable = 1'b1;
        wait_empty("skip_done");
        chk("skip_no_ready1", 32'(r1_seen), 32'd0);

        do_reset();
        mode = 3'b000; swc = 32'd20; v1 = 1'b1;
        d0 = 8'hC3; d2 = 8'h33;
        push(2'd0, 8'hC3, 2);
        push(2'd2, 8'h33, 2);
        enable = 1'b1;
        wait_bits("mchg_wait", 4);
        @(negedge clk);
        mode = 3'b010;
        wait_empty("mchg_done");

        do_reset();
        mode = 3'b010; d2 = 8'hA5;
        enable = 1'b1;
        wait_bits("rstw_wait", 3);
        @(negedge clk);
        chk("rstw_sel_pre", 32'(sel), 32'd2);
        chk("rstw_dv_pre", 32'(d_valid), 32'd1);
        rst = 1'b0;
        #1;
        chk("rstw_dout", 32'(d_out), 32'd0);
        chk("rstw_dvalid", 32'(d_valid), 32'd0);
        chk("rstw_sel", 32'(sel), 32'd0);
        @(negedge clk);
        push(2'd2, 8'hA5, 2);
        rst = 1'b1;
        wait_empty("rstw_done");

        do_reset();
        mode = 3'b000; sym = 32'd1; d0 = 8'hCC;
        push(2'd0, 8'hCC, 1);
        enable = 1'b1;
        wait_empty("s1_cc_done");

        do_reset();
        sym = 32'd0; d0 = 8'h01;
        push(2'd0, 8'h01, 1);
        enable = 1'b1;
        wait_empty("s0_01_done");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/stream_switch_scheduler.md
Name: stream_switch_scheduler

Overview:
- Sequences three 8-bit data sources (data_0/1/2) onto the single serial output d_out of the top-level transmitter.
- Selects the source from mode: fixed source or timed round-robin.
- Consumes words with a valid/ready handshake and shifts each word out MSB-first, holding every bit for a programmable number of clocks.
- Source switching is governed by switch_clk_cycles and takes effect only at word boundaries.

Parameters:
- DATA_W, 8, bits per word and width of each data input.
- CNT_W, 32, width of the symbol/switch counters and their period inputs.

Ports:
- clk  in  1  system clock, single clock domain.
- rst  in  1  asynchronous, active-low reset.
- enable  in  1  scheduler run enable.
- mode  in  3  000 = src0 fixed, 001 = src1 fixed, 010 = src2 fixed, 011 = round-robin, 1xx = reserved (treated as idle).
- symbol_clk_cycles  in  CNT_W  clocks per output bit; 0 treated as 1.
- switch_clk_cycles  in  CNT_W  round-robin dwell in clocks; 0 treated as 1.
- data_0, data_1, data_2  in  DATA_W  source words.
- valid_0, valid_1, valid_2  in  1  source word available.
- ready_0, ready_1, ready_2  out  1  one-cycle consume pulse.
- sel  out  2  currently selected source (0..2).
- d_out  out  1  serial data.
- d_valid  out  1  d_out carries a live bit.
- symbol_strobe  out  1  pulses on the last clock of each bit.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; all counters cleared; switch_pending=0. All outputs 0: sel=0, d_out=0, d_valid=0, ready_x=0, symbol_strobe=0.
- States: IDLE, LOAD, SHIFT.
- IDLE:
  - d_valid=0, d_out=0.
  - Go to LOAD when enable=1 and mode is not 1xx.
- LOAD (mode and enable sampled here only):
  - If enable=0 or mode=1xx: go to IDLE.
  - Fixed modes: sel=mode[1:0]. If that source is valid, ready_sel=1 for this cycle, the shift register loads data_sel, go to SHIFT. Otherwise stay in LOAD.
  - Round-robin with switch_pending=1: search sel+1, sel+2, sel (mod 3) for the first valid source. On a hit, set sel to it, clear switch_pending and the switch timer, then load as above.
  - Round-robin with switch_pending=0: if the current source is invalid, search the same way. If no source is valid, stay in LOAD with sel unchanged.
  - d_valid=0 throughout LOAD.
- SHIFT:
  - d_out = shift_reg MSB; d_valid=1.
  - The symbol counter runs 0..S-1 (S = symbol_clk_cycles). symbol_strobe=1 at count S-1, then shift left and advance the bit count.
  - After DATA_W bits, go to LOAD. Word period = DATA_W*S + 1 clocks.
  - enable or mode changes do not abort the word in progress.
- Switch timer:
  - Counts every clock while mode=011 and state is not IDLE.
  - At count switch_clk_cycles-1, sets switch_pending (sticky) and the timer stops.
  - Cleared when the switch is taken, and whenever mode is not 011.
- Timing: ready_x is asserted only in LOAD, only for sel, and at most one ready is high at a time.
- Mid-operation reset: immediate return to the reset state; the partially sent word is discarded.

Optional Feature:
- Macro: PARITY_EN.
- When defined:
  - After the DATA_W data bits, one extra SHIFT bit is sent carrying even parity of the loaded word (XOR of all bits).
  - The bit lasts S clocks with d_valid=1, and symbol_strobe behaves as for data bits.
  - Word period = (DATA_W+1)*S + 1 clocks.
- When undefined: no parity bit and no parity logic.

Test Plan:
- Fixed source: mode=000, S=2, data_0=8'hCC, valid_0=1 -> ready_0 pulses once per word. d_out = 1,1,0,0,1,1,0,0 with each bit held 2 clocks; d_valid high 16 clocks; 17-clock word period.
- Round-robin dwell: mode=011, S=2, switch_clk_cycles=20, all sources valid -> sel sequence 0,0,1 across the first three words. The switch occurs at the LOAD at clock 34.
- Skip invalid source: mode=011, switch_clk_cycles=1, valid_1=0 -> sel alternates 0,2,0,2; ready_1 never asserts.
- Mode change mid-word: mode 000->010 during bit 3 -> the src0 word completes unchanged; the next word is data_2 (8'h33) with sel=2.
- Reset mid-word: rst low during bit 4 -> same clock edge d_out=0, d_valid=0, sel=0. After release with enable=1, the next word restarts from bit 7.
- PARITY_EN: data_0=8'hCC, S=1 -> 9 bits out, the last bit = 0. With data_0=8'h01, the last bit = 1.
